// File: rtl/sdp_ram_be.sv
// Simple-dual-port word RAM: byte-lane write port A, registered read port B
// with valid/error flags, optional output register and write-to-read forwarding.
module sdp_ram_be #(
  parameter int DATAW      = 32,
  parameter int ADDRW      = 32,
  parameter int WORD_LEN   = 2,
  parameter int DEPTH_LOG2 = 10,
  parameter int OUT_REG    = 0,
  parameter int FWD        = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wea,
  input  logic [DATAW/8-1:0]   bea,
  input  logic [ADDRW-1:0]     addra,
  input  logic [DATAW-1:0]     dina,
  input  logic                 reb,
  input  logic [ADDRW-1:0]     addrb,
  output logic [DATAW-1:0]     doutb,
  output logic                 doutb_valid,
  output logic                 err_a,
  output logic                 err_b
);

  localparam int LANES = DATAW / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int HI    = WORD_LEN + DEPTH_LOG2;

  // Address bits allowed to be non-zero: exactly the word-index field.
  localparam logic [ADDRW-1:0] ONE      = ADDRW'(1);
  localparam logic [ADDRW-1:0] SPAN     = (HI >= ADDRW) ? '1 : (ONE << HI) - ONE;
  localparam logic [ADDRW-1:0] ALIGN    = (ONE << WORD_LEN) - ONE;
  localparam logic [ADDRW-1:0] IDX_MASK = SPAN & ~ALIGN;

  logic [DATAW-1:0] mem [DEPTH] = '{default: '0};

  logic                  legal_a;
  logic                  legal_b;
  logic [DEPTH_LOG2-1:0] idx_a;
  logic [DEPTH_LOG2-1:0] idx_b;
  logic                  do_write;
  logic [DATAW-1:0]      rd_word;

  assign legal_a  = ((addra & ~IDX_MASK) == '0);
  assign legal_b  = ((addrb & ~IDX_MASK) == '0);
  assign idx_a    = addra[HI-1:WORD_LEN];
  assign idx_b    = addrb[HI-1:WORD_LEN];
  assign do_write = rstn && wea && legal_a;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (bea[i]) mem[idx_a][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  // With forwarding, enabled lanes of a same-word write replace the old contents.
  always_comb begin
    rd_word = mem[idx_b];
    if (FWD != 0 && do_write && idx_a == idx_b) begin
      for (int i = 0; i < LANES; i++) begin
        if (bea[i]) rd_word[8*i +: 8] = dina[8*i +: 8];
      end
    end
  end

  logic             s1_valid;
  logic             s1_err;
  logic [DATAW-1:0] s1_data;
  logic             err_a_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
      err_a_q  <= 1'b0;
    end else begin
      s1_valid <= reb;
      s1_err   <= reb && !legal_b;
      err_a_q  <= wea && !legal_a;
      if (reb) s1_data <= legal_b ? rd_word : '0;
    end
  end

  assign err_a = err_a_q;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             s2_valid;
      logic             s2_err;
      logic [DATAW-1:0] s2_data;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign doutb       = s2_data;
      assign doutb_valid = s2_valid;
      assign err_b       = s2_err;
    end else begin : g_no_out_reg
      assign doutb       = s1_data;
      assign doutb_valid = s1_valid;
      assign err_b       = s1_err;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_ram_be.sv
// Directed bench for sdp_ram_be: d0 is OUT_REG=0/FWD=1, d1 is OUT_REG=1/FWD=0,
// both driven by the same stimulus so each scenario covers both configurations.
module tb_sdp_ram_be;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wea;
  logic [3:0]  bea;
  logic [31:0] addra;
  logic [31:0] dina;
  logic        reb;
  logic [31:0] addrb;

  logic [31:0] d0_dout, d1_dout;
  logic        d0_valid, d1_valid;
  logic        d0_erra, d1_erra;
  logic        d0_errb, d1_errb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdp_ram_be #(.DATAW(32), .ADDRW(32), .WORD_LEN(2), .DEPTH_LOG2(4), .OUT_REG(0), .FWD(1)) d0 (
    .clk(clk), .rstn(rstn), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
    .reb(reb), .addrb(addrb), .doutb(d0_dout), .doutb_valid(d0_valid),
    .err_a(d0_erra), .err_b(d0_errb)
  );

  sdp_ram_be #(.DATAW(32), .ADDRW(32), .WORD_LEN(2), .DEPTH_LOG2(4), .OUT_REG(1), .FWD(0)) d1 (
    .clk(clk), .rstn(rstn), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
    .reb(reb), .addrb(addrb), .doutb(d1_dout), .doutb_valid(d1_valid),
    .err_a(d1_erra), .err_b(d1_errb)
  );

  // Advance one rising edge, then settle so outputs and new inputs sit away from the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wea = 1'b0; bea = 4'h0; addra = '0; dina = '0; reb = 1'b0; addrb = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wea = 1'b1; bea = 4'hF; addra = 32'h3C; dina = 32'h12345678;
    reb = 1'b1; addrb = 32'h3C;
    cycle(); cycle(); cycle();
    checks++; if (d0_dout !== 32'h0 || d0_valid !== 1'b0 || d0_erra !== 1'b0 || d0_errb !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_d0: dout=%h valid=%b erra=%b errb=%b, expected all zero", d0_dout, d0_valid, d0_erra, d0_errb);
    end
    checks++; if (d1_dout !== 32'h0 || d1_valid !== 1'b0 || d1_erra !== 1'b0 || d1_errb !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_d1: dout=%h valid=%b erra=%b errb=%b, expected all zero", d1_dout, d1_valid, d1_erra, d1_errb);
    end
    idle();
    rstn = 1'b1;
    cycle();
    reb = 1'b1; addrb = 32'h3C;
    cycle();
    reb = 1'b0;
    checks++; if (d0_valid !== 1'b1 || d0_dout !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_write_ignored_d0: dout=%h valid=%b, expected 00000000 valid 1", d0_dout, d0_valid);
    end
    cycle();
    checks++; if (d1_valid !== 1'b1 || d1_dout !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_write_ignored_d1: dout=%h valid=%b, expected 00000000 valid 1", d1_dout, d1_valid);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      wea = 1'b1; bea = 4'hF; addra = 32'(4 * i); dina = 32'hA5000000 + 32'(i);
      cycle();
    end
    idle();
    for (int i = 0; i < 18; i++) begin
      reb = (i < 16); addrb = 32'(4 * (i % 16));
      cycle();
      if (i < 16) begin
        checks++; if (d0_valid !== 1'b1 || d0_errb !== 1'b0 || d0_dout !== 32'hA5000000 + 32'(i)) begin
          errors++; $display("[TB] FAIL sweep_d0[%0d]: dout=%h valid=%b, expected %h valid 1", i, d0_dout, d0_valid, 32'hA5000000 + 32'(i));
        end
      end else if (i == 16) begin
        checks++; if (d0_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL sweep_d0_end: valid=%b, expected 0", d0_valid);
        end
      end
      if (i >= 1 && i < 17) begin
        checks++; if (d1_valid !== 1'b1 || d1_errb !== 1'b0 || d1_dout !== 32'hA5000000 + 32'(i - 1)) begin
          errors++; $display("[TB] FAIL sweep_d1[%0d]: dout=%h valid=%b, expected %h valid 1", i - 1, d1_dout, d1_valid, 32'hA5000000 + 32'(i - 1));
        end
      end else if (i == 17) begin
        checks++; if (d1_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL sweep_d1_end: valid=%b, expected 0", d1_valid);
        end
      end
    end
    idle();
  endtask

  task automatic test_byte_lanes();
    wea = 1'b1; bea = 4'hF; addra = 32'h8; dina = 32'h11223344;
    cycle();
    bea = 4'b0101; dina = 32'hFFFFFFFF;
    cycle();
    idle();
    reb = 1'b1; addrb = 32'h8;
    cycle();
    reb = 1'b0;
    checks++; if (d0_valid !== 1'b1 || d0_dout !== 32'h11FF33FF) begin
      errors++; $display("[TB] FAIL byte_lanes_d0: dout=%h valid=%b, expected 11ff33ff valid 1", d0_dout, d0_valid);
    end
    cycle();
    checks++; if (d1_valid !== 1'b1 || d1_dout !== 32'h11FF33FF) begin
      errors++; $display("[TB] FAIL byte_lanes_d1: dout=%h valid=%b, expected 11ff33ff valid 1", d1_dout, d1_valid);
    end
    checks++; if (d0_valid !== 1'b0 || d0_dout !== 32'h11FF33FF) begin
      errors++; $display("[TB] FAIL hold_d0: dout=%h valid=%b, expected 11ff33ff valid 0", d0_dout, d0_valid);
    end
  endtask

  task automatic test_collision();
    wea = 1'b1; bea = 4'hF; addra = 32'h10; dina = 32'hDEADBEEF;
    cycle();
    bea = 4'b0011; dina = 32'h00000000;
    reb = 1'b1; addrb = 32'h10;
    cycle();
    wea = 1'b0; bea = 4'h0;
    checks++; if (d0_valid !== 1'b1 || d0_dout !== 32'hDEAD0000) begin
      errors++; $display("[TB] FAIL collision_fwd: dout=%h valid=%b, expected dead0000 valid 1", d0_dout, d0_valid);
    end
    cycle();
    reb = 1'b0;
    checks++; if (d1_valid !== 1'b1 || d1_dout !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL collision_nofwd: dout=%h valid=%b, expected deadbeef valid 1", d1_dout, d1_valid);
    end
    checks++; if (d0_valid !== 1'b1 || d0_dout !== 32'hDEAD0000) begin
      errors++; $display("[TB] FAIL collision_next_d0: dout=%h valid=%b, expected dead0000 valid 1", d0_dout, d0_valid);
    end
    cycle();
    checks++; if (d1_valid !== 1'b1 || d1_dout !== 32'hDEAD0000) begin
      errors++; $display("[TB] FAIL collision_next_d1: dout=%h valid=%b, expected dead0000 valid 1", d1_dout, d1_valid);
    end
    idle();
  endtask

  task automatic test_illegal();
    cycle();
    wea = 1'b1; bea = 4'hF; addra = 32'h2; dina = 32'hCAFEF00D;
    cycle();
    checks++; if (d0_erra !== 1'b1 || d1_erra !== 1'b1) begin
      errors++; $display("[TB] FAIL err_a_misaligned: d0=%b d1=%b, expected 1", d0_erra, d1_erra);
    end
    addra = 32'h40;
    cycle();
    checks++; if (d0_erra !== 1'b1 || d1_erra !== 1'b1) begin
      errors++; $display("[TB] FAIL err_a_range: d0=%b d1=%b, expected 1", d0_erra, d1_erra);
    end
    // Legal write with no lanes enabled, colliding with a read of the same word.
    bea = 4'h0; addra = 32'h0; dina = 32'hFFFFFFFF;
    reb = 1'b1; addrb = 32'h0;
    cycle();
    checks++; if (d0_erra !== 1'b0 || d1_erra !== 1'b0) begin
      errors++; $display("[TB] FAIL err_a_clear: d0=%b d1=%b, expected 0", d0_erra, d1_erra);
    end
    checks++; if (d0_valid !== 1'b1 || d0_errb !== 1'b0 || d0_dout !== 32'hA5000000) begin
      errors++; $display("[TB] FAIL illegal_unchanged_d0: dout=%h valid=%b errb=%b, expected a5000000 1 0", d0_dout, d0_valid, d0_errb);
    end
    wea = 1'b0;
    addrb = 32'h41;
    cycle();
    reb = 1'b0;
    checks++; if (d0_valid !== 1'b1 || d0_errb !== 1'b1 || d0_dout !== 32'h0) begin
      errors++; $display("[TB] FAIL illegal_read_d0: dout=%h valid=%b errb=%b, expected 00000000 1 1", d0_dout, d0_valid, d0_errb);
    end
    checks++; if (d1_valid !== 1'b1 || d1_errb !== 1'b0 || d1_dout !== 32'hA5000000) begin
      errors++; $display("[TB] FAIL illegal_unchanged_d1: dout=%h valid=%b errb=%b, expected a5000000 1 0", d1_dout, d1_valid, d1_errb);
    end
    cycle();
    checks++; if (d1_valid !== 1'b1 || d1_errb !== 1'b1 || d1_dout !== 32'h0) begin
      errors++; $display("[TB] FAIL illegal_read_d1: dout=%h valid=%b errb=%b, expected 00000000 1 1", d1_dout, d1_valid, d1_errb);
    end
    checks++; if (d0_valid !== 1'b0 || d0_errb !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_after_d0: valid=%b errb=%b, expected 0 0", d0_valid, d0_errb);
    end
    idle();
  endtask

  task automatic test_reset_mid_read();
    cycle();
    reb = 1'b1; addrb = 32'h3C;
    cycle();
    reb = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; if (d1_valid !== 1'b0 || d1_dout !== 32'h0 || d0_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_clear: d1 dout=%h valid=%b d0 valid=%b, expected 0 0 0", d1_dout, d1_valid, d0_valid);
    end
    cycle();
    checks++; if (d1_valid !== 1'b0 || d1_dout !== 32'h0) begin
      errors++; $display("[TB] FAIL mid_reset_discard: dout=%h valid=%b, expected 00000000 valid 0", d1_dout, d1_valid);
    end
    rstn = 1'b1;
    cycle();
    checks++; if (d1_valid !== 1'b0 || d0_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_release: d0 valid=%b d1 valid=%b, expected 0 0", d0_valid, d1_valid);
    end
    reb = 1'b1; addrb = 32'h3C;
    cycle();
    reb = 1'b0;
    checks++; if (d0_valid !== 1'b1 || d0_dout !== 32'hA500000F) begin
      errors++; $display("[TB] FAIL mid_reset_keep_d0: dout=%h valid=%b, expected a500000f valid 1", d0_dout, d0_valid);
    end
    cycle();
    checks++; if (d1_valid !== 1'b1 || d1_dout !== 32'hA500000F) begin
      errors++; $display("[TB] FAIL mid_reset_keep_d1: dout=%h valid=%b, expected a500000f valid 1", d1_dout, d1_valid);
    end
    idle();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    test_reset();
    test_sweep();
    test_byte_lanes();
    test_collision();
    test_illegal();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
